// File: rtl/adc_pkg.sv
// Shared ADC frame constants and arbiter state encoding.
// Also consumed by the SPI capture stage.
package adc_pkg;

    localparam int ADC_CH_W   = 4;
    localparam int ADC_MAX_CH = 16;
    localparam int ADC_DATA_W = 12;

    typedef enum logic {
        ARB_IDLE,
        ARB_RESP
    } arb_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick, searching upward from last_grant+1.
// The last_grant register is owned by the parent.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last_grant,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx
);

    always_comb begin
        logic found;
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        // First pass above last_grant, second pass wraps from zero.
        for (int j = 0; j < NUM_REQ; j++) begin
            if (!found && req[j] && (j > int'(last_grant))) begin
                found     = 1'b1;
                grant[j]  = 1'b1;
                grant_idx = IDX_W'(j);
            end
        end
        for (int j = 0; j < NUM_REQ; j++) begin
            if (!found && req[j]) begin
                found     = 1'b1;
                grant[j]  = 1'b1;
                grant_idx = IDX_W'(j);
            end
        end
    end

endmodule

// File: rtl/adc_read_arbiter.sv
// ADC reading bank with fresh tracking, shared among requesters
// through a round-robin req/ack read port.
module adc_read_arbiter
    import adc_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int NUM_CH  = 16,
    parameter int DATA_W  = ADC_DATA_W
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         upd_valid,
    input  logic [ADC_CH_W-1:0]          upd_ch,
    input  logic [DATA_W-1:0]            upd_data,
    input  logic [NUM_REQ-1:0]           req,
    input  logic [NUM_REQ*ADC_CH_W-1:0]  req_ch,
    output logic [NUM_REQ-1:0]           ack,
    output logic [DATA_W-1:0]            rd_data,
    output logic                         rd_fresh,
    output logic                         rd_err,
    output logic [NUM_CH-1:0]            fresh_mask,
    output logic [7:0]                   overrun_cnt
);

    localparam int IDX_W = $clog2(NUM_REQ);

    arb_state_t            state_q, state_d;
    logic [IDX_W-1:0]      last_q, last_d;
    logic [NUM_REQ-1:0]    ack_q, ack_d;
    logic [DATA_W-1:0]     rdat_q, rdat_d;
    logic                  rfresh_q, rfresh_d;
    logic                  err_q, err_d;
    logic [ADC_CH_W-1:0]   ch_q, ch_d;
    logic [NUM_CH-1:0]     fmask_q, fmask_d;
    logic [7:0]            ovr_q, ovr_d;
    logic [DATA_W-1:0]     bank_q [NUM_CH];
    logic [DATA_W-1:0]     bank_d [NUM_CH];

    logic [NUM_REQ-1:0]    gnt;
    logic [IDX_W-1:0]      gnt_idx;
    logic [ADC_CH_W-1:0]   win_ch;
    logic [DATA_W-1:0]     win_data;
    logic                  win_fresh;
    logic                  win_err;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr (
        .req        (req),
        .last_grant (last_q),
        .grant      (gnt),
        .grant_idx  (gnt_idx)
    );

    // Channels with no bank entry fall through as errors.
    always_comb begin
        win_ch    = '0;
        win_data  = '0;
        win_fresh = 1'b0;
        win_err   = 1'b1;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
                win_ch = req_ch[i*ADC_CH_W +: ADC_CH_W];
            end
        end
        for (int c = 0; c < NUM_CH; c++) begin
            if (win_ch == ADC_CH_W'(c)) begin
                win_err   = 1'b0;
                win_data  = bank_q[c];
                win_fresh = fmask_q[c];
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        last_d   = last_q;
        ack_d    = '0;
        rdat_d   = rdat_q;
        rfresh_d = rfresh_q;
        err_d    = err_q;
        ch_d     = ch_q;
        fmask_d  = fmask_q;
        ovr_d    = ovr_q;
        bank_d   = bank_q;

        unique case (state_q)
            ARB_IDLE: begin
                if (|req) begin
                    state_d  = ARB_RESP;
                    last_d   = gnt_idx;
                    ack_d    = gnt;
                    rdat_d   = win_data;
                    rfresh_d = win_fresh;
                    err_d    = win_err;
                    ch_d     = win_ch;
                end
            end
            ARB_RESP: begin
                state_d = ARB_IDLE;
                for (int c = 0; c < NUM_CH; c++) begin
                    if (!err_q && (ch_q == ADC_CH_W'(c))) begin
                        fmask_d[c] = 1'b0;
                    end
                end
            end
            default: state_d = ARB_IDLE;
        endcase

        // Applied after the clear so a same-edge update keeps the flag set.
        if (upd_valid) begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (upd_ch == ADC_CH_W'(c)) begin
                    bank_d[c]  = upd_data;
                    fmask_d[c] = 1'b1;
                    if (fmask_q[c] && (ovr_q != 8'hFF)) begin
                        ovr_d = ovr_q + 8'd1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ARB_IDLE;
            last_q   <= IDX_W'(NUM_REQ - 1);
            ack_q    <= '0;
            rdat_q   <= '0;
            rfresh_q <= 1'b0;
            err_q    <= 1'b0;
            ch_q     <= '0;
            fmask_q  <= '0;
            ovr_q    <= '0;
            bank_q   <= '{default: '0};
        end else begin
            state_q  <= state_d;
            last_q   <= last_d;
            ack_q    <= ack_d;
            rdat_q   <= rdat_d;
            rfresh_q <= rfresh_d;
            err_q    <= err_d;
            ch_q     <= ch_d;
            fmask_q  <= fmask_d;
            ovr_q    <= ovr_d;
            bank_q   <= bank_d;
        end
    end

    assign ack         = ack_q;
    assign rd_data     = rdat_q;
    assign rd_fresh    = rfresh_q;
    assign rd_err      = err_q;
    assign fresh_mask  = fmask_q;
    assign overrun_cnt = ovr_q;

endmodule

// File: tb/tb_adc_read_arbiter.sv
// Directed bench for adc_read_arbiter, NUM_REQ=4, NUM_CH=8.
// Inputs change and outputs are sampled on the falling edge.
module tb_adc_read_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        upd_valid = 1'b0;
    logic [3:0]  upd_ch = '0;
    logic [11:0] upd_data = '0;
    logic [3:0]  req = '0;
    logic [15:0] req_ch = '0;
    logic [3:0]  ack;
    logic [11:0] rd_data;
    logic        rd_fresh;
    logic        rd_err;
    logic [7:0]  fresh_mask;
    logic [7:0]  overrun_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    adc_read_arbiter #(
        .NUM_REQ (4),
        .NUM_CH  (8),
        .DATA_W  (12)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .upd_valid   (upd_valid),
        .upd_ch      (upd_ch),
        .upd_data    (upd_data),
        .req         (req),
        .req_ch      (req_ch),
        .ack         (ack),
        .rd_data     (rd_data),
        .rd_fresh    (rd_fresh),
        .rd_err      (rd_err),
        .fresh_mask  (fresh_mask),
        .overrun_cnt (overrun_cnt)
    );

    task automatic upd(input logic [3:0] ch, input logic [11:0] d);
        @(negedge clk);
        upd_valid = 1'b1;
        upd_ch    = ch;
        upd_data  = d;
        @(negedge clk);
        upd_valid = 1'b0;
    endtask

    task automatic test_reset;
        repeat (2) @(negedge clk);
        checks++;
        if (ack !== 4'h0) begin
            errors++;
            $display("FAIL reset_ack got %h want 0", ack);
        end
        checks++;
        if ({rd_data, rd_fresh, rd_err} !== 14'h0) begin
            errors++;
            $display("FAIL reset_rd got %h/%b/%b want 0", rd_data, rd_fresh, rd_err);
        end
        checks++;
        if ({fresh_mask, overrun_cnt} !== 16'h0) begin
            errors++;
            $display("FAIL reset_mask got %h/%h want 0", fresh_mask, overrun_cnt);
        end
        reset = 1'b0;
    endtask

    task automatic test_round_robin;
        logic [3:0] exp;
        int w;
        req    = 4'hF;
        req_ch = 16'h0000;
        for (int g = 0; g < 5; g++) begin
            w   = g % 4;
            exp = 4'b0001 << w;
            @(negedge clk);
            checks++;
            if (ack !== exp) begin
                errors++;
                $display("FAIL rr_grant%0d got %b want %b", g, ack, exp);
            end
            req[w] = 1'b0;
            @(negedge clk);
            checks++;
            if (ack !== 4'h0) begin
                errors++;
                $display("FAIL rr_gap%0d got %b want 0000", g, ack);
            end
            req[w] = 1'b1;
        end
        req = 4'h0;
    endtask

    task automatic test_basic;
        upd(4'd3, 12'hA5C);
        req    = 4'b0010;
        req_ch = 16'h0030;
        @(negedge clk);
        checks++;
        if ({ack, rd_data, rd_fresh, rd_err} !== {4'b0010, 12'hA5C, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL basic_read got %b/%h/%b/%b want 0010/a5c/1/0",
                     ack, rd_data, rd_fresh, rd_err);
        end
        @(negedge clk);
        checks++;
        if ({ack, fresh_mask} !== {4'b0000, 8'h00}) begin
            errors++;
            $display("FAIL basic_clear got %b/%h want 0000/00", ack, fresh_mask);
        end
        @(negedge clk);
        checks++;
        if ({ack, rd_data, rd_fresh} !== {4'b0010, 12'hA5C, 1'b0}) begin
            errors++;
            $display("FAIL basic_reread got %b/%h/%b want 0010/a5c/0",
                     ack, rd_data, rd_fresh);
        end
        req = 4'h0;
        @(negedge clk);
    endtask

    task automatic test_collision;
        upd(4'd5, 12'h0FF);
        upd_valid = 1'b1;
        upd_ch    = 4'd5;
        upd_data  = 12'h123;
        req       = 4'b0001;
        req_ch    = 16'h0005;
        @(negedge clk);
        upd_data = 12'h456;
        req      = 4'h0;
        checks++;
        if ({ack, rd_data, rd_fresh} !== {4'b0001, 12'h0FF, 1'b1}) begin
            errors++;
            $display("FAIL coll_latch got %b/%h/%b want 0001/0ff/1",
                     ack, rd_data, rd_fresh);
        end
        @(negedge clk);
        upd_valid = 1'b0;
        checks++;
        if ({ack, fresh_mask, overrun_cnt} !== {4'b0000, 8'h20, 8'd2}) begin
            errors++;
            $display("FAIL coll_clear got %b/%h/%0d want 0000/20/2",
                     ack, fresh_mask, overrun_cnt);
        end
        req    = 4'b0001;
        req_ch = 16'h0005;
        @(negedge clk);
        req = 4'h0;
        checks++;
        if ({ack, rd_data, rd_fresh} !== {4'b0001, 12'h456, 1'b1}) begin
            errors++;
            $display("FAIL coll_newdata got %b/%h/%b want 0001/456/1",
                     ack, rd_data, rd_fresh);
        end
        @(negedge clk);
        checks++;
        if (fresh_mask !== 8'h00) begin
            errors++;
            $display("FAIL coll_mask got %h want 00", fresh_mask);
        end
    endtask

    task automatic test_overrun;
        upd_valid = 1'b1;
        upd_ch    = 4'd7;
        upd_data  = 12'h777;
        repeat (10) @(negedge clk);
        checks++;
        if (overrun_cnt !== 8'd11) begin
            errors++;
            $display("FAIL ovr_count got %0d want 11", overrun_cnt);
        end
        repeat (290) @(negedge clk);
        checks++;
        if ({overrun_cnt, fresh_mask} !== {8'd255, 8'h80}) begin
            errors++;
            $display("FAIL ovr_sat got %0d/%h want 255/80", overrun_cnt, fresh_mask);
        end
        upd_ch   = 4'd15;
        upd_data = 12'hFFF;
        @(negedge clk);
        upd_valid = 1'b0;
        checks++;
        if ({overrun_cnt, fresh_mask} !== {8'd255, 8'h80}) begin
            errors++;
            $display("FAIL ovr_ignore got %0d/%h want 255/80", overrun_cnt, fresh_mask);
        end
        req    = 4'b0100;
        req_ch = 16'h0700;
        @(negedge clk);
        req = 4'h0;
        checks++;
        if ({ack, rd_data, rd_fresh} !== {4'b0100, 12'h777, 1'b1}) begin
            errors++;
            $display("FAIL ovr_read got %b/%h/%b want 0100/777/1",
                     ack, rd_data, rd_fresh);
        end
        @(negedge clk);
        upd(4'd6, 12'h066);
    endtask

    task automatic test_error;
        req    = 4'b1000;
        req_ch = 16'hC000;
        @(negedge clk);
        req = 4'h0;
        checks++;
        if ({ack, rd_data, rd_fresh, rd_err} !== {4'b1000, 12'h000, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL err_read got %b/%h/%b/%b want 1000/000/0/1",
                     ack, rd_data, rd_fresh, rd_err);
        end
        @(negedge clk);
        checks++;
        if ({ack, fresh_mask, overrun_cnt} !== {4'b0000, 8'h40, 8'd255}) begin
            errors++;
            $display("FAIL err_mask got %b/%h/%0d want 0000/40/255",
                     ack, fresh_mask, overrun_cnt);
        end
    endtask

    task automatic test_mid_reset;
        req    = 4'b0010;
        req_ch = 16'h0060;
        @(negedge clk);
        checks++;
        if (ack !== 4'b0010) begin
            errors++;
            $display("FAIL mrst_pre got %b want 0010", ack);
        end
        #1 reset = 1'b1;
        req    = 4'b1001;
        req_ch = 16'h6006;
        #1;
        checks++;
        if ({ack, rd_data, rd_fresh, rd_err} !== 18'h0) begin
            errors++;
            $display("FAIL mrst_out got %b/%h/%b/%b want all 0",
                     ack, rd_data, rd_fresh, rd_err);
        end
        checks++;
        if ({fresh_mask, overrun_cnt} !== 16'h0) begin
            errors++;
            $display("FAIL mrst_state got %h/%h want 0", fresh_mask, overrun_cnt);
        end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        req = 4'h0;
        checks++;
        if ({ack, rd_data} !== {4'b0001, 12'h000}) begin
            errors++;
            $display("FAIL mrst_first got %b/%h want 0001/000", ack, rd_data);
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_basic();
        test_collision();
        test_overrun();
        test_error();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
